// File: rtl/sr_latch_ctrl_if.sv
// Request/latch bundle between requesters, controller and the shared SR latch.
// The controller takes the slave view; control logic/bench takes master.
interface sr_latch_ctrl_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op;
  logic             q_in;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             s_n;
  logic             r_n;
  logic             busy;
  logic             err;

  modport master (
    output req, op, q_in,
    input  gnt, done, s_n, r_n, busy, err
  );

  modport slave (
    input  req, op, q_in,
    output gnt, done, s_n, r_n, busy, err
  );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer driving one active-low SR latch with timed pulses.
// Define SR_CTRL_VERIFY_EN to compare q_in against the written value.
module sr_latch_ctrl #(
  parameter int N_REQ      = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input logic           clk,
  input logic           rst,
  sr_latch_ctrl_if.slave bus
);
  localparam int MAXC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [PW-1:0]    ptr, ptr_d;
  logic [PW-1:0]    sel, sel_d;
  logic [PW-1:0]    pick;
  logic             op_q, op_d;
  logic             any;
  int               best, d;

  logic [N_REQ-1:0] gnt, gnt_d;
  logic [N_REQ-1:0] done, done_d;
  logic             s_n, s_n_d;
  logic             r_n, r_n_d;
  logic             busy, busy_d;
  logic             err, err_d;

  // Nearest requester after the last grant, wrapping around.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    best = N_REQ;
    d    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i + N_REQ - 1 - int'(ptr)) % N_REQ;
      if (bus.req[i] && d < best) begin
        best = d;
        pick = PW'(i);
        any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= PW'(N_REQ - 1);
      sel   <= '0;
      op_q  <= 1'b0;
      gnt   <= '0;
      done  <= '0;
      s_n   <= 1'b1;
      r_n   <= 1'b1;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ptr   <= ptr_d;
      sel   <= sel_d;
      op_q  <= op_d;
      gnt   <= gnt_d;
      done  <= done_d;
      s_n   <= s_n_d;
      r_n   <= r_n_d;
      busy  <= busy_d;
      err   <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ptr_d   = ptr;
    sel_d   = sel;
    op_d    = op_q;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_d = PULSE;
          cnt_d   = CW'(PULSE_CYC - 1);
          sel_d   = pick;
          op_d    = bus.op[pick];
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_d = SETTLE;
          cnt_d   = CW'(SETTLE_CYC - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_d = CHECK;
        else           cnt_d   = cnt - 1'b1;
      end
      CHECK: begin
        state_d = IDLE;
        ptr_d   = sel;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only one line is ever pulled low, and only while in PULSE.
  always_comb begin
    gnt_d  = gnt;
    done_d = '0;
    s_n_d  = 1'b1;
    r_n_d  = 1'b1;
`ifdef SR_CTRL_VERIFY_EN
    err_d  = err;
`else
    err_d  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (any) begin
          gnt_d = N_REQ'(1) << pick;
          s_n_d = ~bus.op[pick];
          r_n_d = bus.op[pick];
        end
      end
      PULSE: begin
        s_n_d = (cnt == '0) | ~op_q;
        r_n_d = (cnt == '0) | op_q;
      end
      SETTLE: begin
        s_n_d = 1'b1;
        r_n_d = 1'b1;
      end
      CHECK: begin
        done_d = gnt;
        gnt_d  = '0;
`ifdef SR_CTRL_VERIFY_EN
        err_d  = err | (bus.q_in != op_q);
`endif
      end
      default: gnt_d = '0;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.gnt  = gnt;
  assign bus.done = done;
  assign bus.s_n  = s_n;
  assign bus.r_n  = r_n;
  assign bus.busy = busy;
  assign bus.err  = err;
endmodule
